// File: rtl/priority_encoder_12to4.sv
// Registered 12-request priority encoder: reports the winning and runner-up request
// codes (bit i -> code i+1, code 0 = none) one clock after sampling the request vector.
module priority_encoder_12to4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] r,
    output logic [3:0]  y,
    output logic [3:0]  y2
);

    logic [3:0]  w_yNext;
    logic [3:0]  w_y2Next;
    logic [11:0] w_masked;
    logic [3:0]  r_y;
    logic [3:0]  r_y2;

    // Later (higher) indices overwrite earlier ones, so the top set bit wins.
    function automatic logic [3:0] encode12(input logic [11:0] req);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (req[i]) begin
                code = 4'(i + 1);
            end
        end
        return code;
    endfunction

    // Runner-up is found by clearing the winning bit and encoding what remains.
    always_comb begin
        w_yNext  = encode12(r);
        w_masked = r;
        if (w_yNext != 4'd0) begin
            w_masked[w_yNext - 4'd1] = 1'b0;
        end
        w_y2Next = encode12(w_masked);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y  <= 4'd0;
            r_y2 <= 4'd0;
        end else begin
            r_y  <= w_yNext;
            r_y2 <= w_y2Next;
        end
    end

    assign y  = r_y;
    assign y2 = r_y2;

endmodule

// File: tb/tb_priority_encoder_12to4.sv
// Self-checking bench for priority_encoder_12to4: arithmetic reference model checked
// every cycle, plus hand-computed literal vectors, an exhaustive sweep and random traffic.
module tb_priority_encoder_12to4;

    logic        clk;
    logic        rst_n;
    logic [11:0] r;
    logic [3:0]  y;
    logic [3:0]  y2;

    int checks   = 0;
    int failures = 0;

    logic       expValid = 1'b0;
    logic [3:0] expY;
    logic [3:0] expY2;

    priority_encoder_12to4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .r     (r),
        .y     (y),
        .y2    (y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code of the top set bit is the bit length of the value (floor(log2(v)) + 1).
    function automatic logic [3:0] modelTop(input int v);
        int n;
        n = 0;
        while ((1 << n) <= v) n++;
        return 4'(n);
    endfunction

    function automatic logic [3:0] modelSecond(input int v);
        logic [3:0] t;
        t = modelTop(v);
        if (t == 4'd0) return 4'd0;
        return modelTop(v - (1 << (int'(t) - 1)));
    endfunction

    task automatic countCheck(input string name, input logic ok,
                              input logic [3:0] actY, input logic [3:0] actY2,
                              input logic [3:0] reqY, input logic [3:0] reqY2);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got y=%0d y2=%0d, expected y=%0d y2=%0d (r=%h t=%0t)",
                     name, actY, actY2, reqY, reqY2, r, $time);
        end
    endtask

    // Model tracks what the DUT should register at each edge from the sampled inputs.
    always @(posedge clk) begin
        expValid <= 1'b1;
        expY     <= rst_n ? modelTop(int'(r)) : 4'd0;
        expY2    <= rst_n ? modelSecond(int'(r)) : 4'd0;
    end

    always @(negedge clk) begin
        if (expValid) begin
            countCheck("model", (y === expY) && (y2 === expY2), y, y2, expY, expY2);
            countCheck("invariant", (y2 == 4'd0) || (y > y2 && y <= 4'd12), y, y2, expY, expY2);
        end
    end

    task automatic applyStimulus(input logic rn, input logic [11:0] rv);
        @(negedge clk);
        rst_n = rn;
        r     = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ey, input logic [3:0] ey2);
        countCheck(name, (y === ey) && (y2 === ey2), y, y2, ey, ey2);
    endtask

    typedef struct {
        logic [11:0] rv;
        logic [3:0]  ey;
        logic [3:0]  ey2;
    } vec_t;

    vec_t vecs[10] = '{
        '{12'b1000_0000_0000, 4'd12, 4'd0},
        '{12'b0000_1000_0000, 4'd8,  4'd0},
        '{12'b0000_0000_0001, 4'd1,  4'd0},
        '{12'b0000_1100_0000, 4'd8,  4'd7},
        '{12'b0000_1010_0000, 4'd8,  4'd6},
        '{12'b0000_1000_1000, 4'd8,  4'd4},
        '{12'b0000_1010_1000, 4'd8,  4'd6},
        '{12'b1000_0000_0001, 4'd12, 4'd1},
        '{12'b0000_0000_0000, 4'd0,  4'd0},
        '{12'b0000_0000_0011, 4'd2,  4'd1}
    };

    initial begin
        rst_n = 1'b0;
        r     = 12'hFFF;

        applyStimulus(1'b0, 12'hFFF);
        checkOutput("reset1", 4'd0, 4'd0);
        applyStimulus(1'b0, 12'hFFF);
        checkOutput("reset2", 4'd0, 4'd0);
        applyStimulus(1'b1, 12'hFFF);
        checkOutput("release", 4'd12, 4'd11);

        // Pin the reference model itself against hand-computed values.
        for (int i = 0; i < 10; i++) begin
            countCheck("modelpin", (modelTop(int'(vecs[i].rv)) == vecs[i].ey) &&
                       (modelSecond(int'(vecs[i].rv)) == vecs[i].ey2),
                       modelTop(int'(vecs[i].rv)), modelSecond(int'(vecs[i].rv)),
                       vecs[i].ey, vecs[i].ey2);
        end

        // Back-to-back vectors, one new request every cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].rv);
            checkOutput("vector", vecs[i].ey, vecs[i].ey2);
        end

        applyStimulus(1'b0, 12'b0000_1010_1000);
        checkOutput("midreset", 4'd0, 4'd0);
        applyStimulus(1'b1, 12'b0000_1010_1000);
        checkOutput("midrelease", 4'd8, 4'd6);

        for (int v = 0; v < 4096; v++) begin
            applyStimulus(1'b1, 12'(v));
        end

        for (int k = 0; k < 2000; k++) begin
            applyStimulus(($urandom_range(0, 15) != 0), 12'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_encoder_12to4.md
# priority_encoder_12to4

Registered 12-request priority encoder. Each cycle it reports the highest-priority active request line and the second-highest active request line as 4-bit codes. It sits between a 12-bit request vector (interrupt/arbiter style) and downstream logic that needs the winner and runner-up indices. Code 0 means "no request", so no separate valid flag is required.

## Interface
- No parameters; widths fixed (12 requests, 4-bit codes).
- clk  input  1  rising-edge clock; the only clock in the block
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- r  input  12  request vector; r[11] has the highest priority, r[0] the lowest
- y  output  4  registered code of the highest-priority active request
- y2  output  4  registered code of the second-highest-priority active request

## Operation
- Code mapping: request bit r[i] maps to code i+1, so r[11] → 12 (4'b1100) and r[0] → 1 (4'b0001).
- Code 0 means no request at that rank. Codes 13–15 are never produced.
- First encoder: y_next = code of the highest index i with r[i]=1, or 0 if r == 0.
- Second encoder: y2_next = code of the highest index j < (y_next−1) with r[j]=1.
  - y2_next is 0 if fewer than two bits of r are set.
  - Implement as: mask off the winning bit, then encode the remainder with the same rule.
- Both encoders are pure combinational priority logic from r. Only the outputs are registered.
- Invariant: whenever y2 ≠ 0, y > y2. Also y2 ≠ 0 implies y ≠ 0.
- Lower-priority bits beyond the top two are ignored.
- No X-propagation requirement beyond normal synthesis semantics. r is assumed to be synchronous to clk.

## Timing
- Register stage, on each rising clk edge:
  - If rst_n = 0: y ← 0 and y2 ← 0.
  - Otherwise: y ← y_next(r) and y2 ← y2_next(r).
- Latency is exactly 1 cycle. The value of r sampled at edge N appears on y/y2 after edge N. There is no combinational path from r to the outputs.
- Throughput: a new r is accepted every cycle. There is no handshake or stall.
- Reset value of every output is 0.
- Reset is synchronous: asserting rst_n mid-stream has no effect until the next rising edge, at which point the outputs go to 0 regardless of r.
- On the first edge with rst_n = 1, the outputs reflect the r sampled at that edge.
- r changing between edges has no effect on the outputs until the next edge.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with r = 12'hFFF → y = 0 and y2 = 0. Release rst_n → the next edge gives y = 12, y2 = 11.
- Single bits: r = 12'b1000_0000_0000 → y = 12, y2 = 0. r = 12'b0000_1000_0000 → y = 8, y2 = 0. r = 12'b0000_0000_0001 → y = 1, y2 = 0.
- Two or more bits:
  - 12'b0000_1100_0000 → y = 8, y2 = 7
  - 12'b0000_1010_0000 → y = 8, y2 = 6
  - 12'b0000_1000_1000 → y = 8, y2 = 4
  - 12'b0000_1010_1000 → y = 8, y2 = 6
- Extremes: r = 12'b1000_0000_0001 → y = 12, y2 = 1. r = 12'b0000_0000_0000 → y = 0, y2 = 0. r = 12'b0000_0000_0011 → y = 2, y2 = 1.
- Latency and back-to-back: change r every cycle through the vectors above. Each output pair must appear exactly one edge after its r is sampled, with no skipped or repeated values.
- Mid-stream reset: apply rst_n = 0 for one edge while r = 12'b0000_1010_1000 → outputs go to 0 at that edge. Outputs return to y = 8, y2 = 6 one edge after rst_n returns to 1.
- Exhaustive: sweep all 4096 values of r against a reference model. Check the y/y2 mapping and the invariant y > y2 whenever y2 ≠ 0.
